// File: rtl/stream_rr_merge.sv
// stream_rr_merge: per-channel FIFOs drained by a burst-capable round-robin arbiter onto one registered, tagged output stream
module stream_rr_merge #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int BURST_LEN = 1,
  localparam int ID_W = $clog2(NUM_IN)
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         ap_start,
  output logic                         ap_idle,
  input  logic [NUM_IN*DATA_WIDTH-1:0] Input_V_TDATA,
  input  logic [NUM_IN-1:0]            Input_V_TVALID,
  output logic [NUM_IN-1:0]            Input_V_TREADY,
  output logic [DATA_WIDTH-1:0]        Output_1_V_TDATA,
  output logic [ID_W-1:0]              Output_1_V_TDEST,
  output logic                         Output_1_V_TVALID,
  input  logic                         Output_1_V_TREADY
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [AW:0] PTR_WRAP = {1'b1, {AW{1'b0}}};
  logic run;
  logic [DATA_WIDTH-1:0] mem [NUM_IN][FIFO_DEPTH];
  logic [AW:0] wp [NUM_IN];
  logic [AW:0] rp [NUM_IN];
  logic [NUM_IN-1:0] full, empty, push, pop;
  logic [ID_W-1:0] ptr, sel;
  logic [CW-1:0] cnt;
  logic load, stay, found;
  for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
    assign empty[i] = wp[i] == rp[i];
    assign full[i] = (wp[i] ^ rp[i]) == PTR_WRAP;
    assign push[i] = Input_V_TVALID[i] & Input_V_TREADY[i];
    assign pop[i] = load & (sel == ID_W'(i));
  end
  assign Input_V_TREADY = {NUM_IN{run}} & ~full;
  assign load = (~Output_1_V_TVALID | Output_1_V_TREADY) & ~&empty;
  assign stay = ~empty[ptr] & (cnt < CW'(BURST_LEN));
  assign ap_idle = &empty & ~Output_1_V_TVALID;
  always_comb begin
    sel = ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_IN; k++) begin
      if (!found && !empty[(int'(ptr) + k) % NUM_IN]) begin
        sel = ID_W'((int'(ptr) + k) % NUM_IN);
        found = 1'b1;
      end
    end
    sel = stay ? ptr : sel;
  end
  always_ff @(posedge ap_clk) begin
    for (int i = 0; i < NUM_IN; i++)
      if (push[i]) mem[i][wp[i][AW-1:0]] <= Input_V_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_IN; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (push[i]) wp[i] <= wp[i] + PTR_ONE;
        if (pop[i]) rp[i] <= rp[i] + PTR_ONE;
      end
    end
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      run <= 1'b0;
      ptr <= '0;
      cnt <= '0;
      Output_1_V_TVALID <= 1'b0;
      Output_1_V_TDATA <= '0;
      Output_1_V_TDEST <= '0;
    end else begin
      run <= run | ap_start;
      if (load) begin
        Output_1_V_TDATA <= mem[sel][rp[sel][AW-1:0]];
        Output_1_V_TDEST <= sel;
        Output_1_V_TVALID <= 1'b1;
        ptr <= sel;
        cnt <= stay ? cnt + CW'(1) : CW'(1);
      end else if (Output_1_V_TREADY) begin
        Output_1_V_TVALID <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_rr_merge.sv
// tb_stream_rr_merge: directed checks of reset, start gating, latency, round robin, burst, backpressure and mid-run reset
module tb_stream_rr_merge;
  logic clk = 1'b0;
  logic rst_n, start, out_ready;
  logic [63:0] in_data;
  logic [1:0] in_valid;
  logic [1:0] rdy1, rdy3;
  logic [31:0] data1, data3;
  logic dest1, dest3, valid1, valid3, idle1, idle3;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] q1_d[$];
  logic [31:0] q3_d[$];
  logic q1_t[$];
  logic q3_t[$];
  logic [31:0] exp_rr_d [8] = '{32'hA0, 32'hB0, 32'hA1, 32'hB1, 32'hA2, 32'hB2, 32'hA3, 32'hB3};
  logic exp_rr_t [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  logic [31:0] exp_bu_d [8] = '{32'hA0, 32'hA1, 32'hA2, 32'hB0, 32'hB1, 32'hB2, 32'hA3, 32'hB3};
  logic exp_bu_t [8] = '{0, 0, 0, 1, 1, 1, 0, 1};
  always #5 clk = ~clk;
  stream_rr_merge #(.DATA_WIDTH(32), .NUM_IN(2), .FIFO_DEPTH(4), .BURST_LEN(1)) d1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start), .ap_idle(idle1),
    .Input_V_TDATA(in_data), .Input_V_TVALID(in_valid), .Input_V_TREADY(rdy1),
    .Output_1_V_TDATA(data1), .Output_1_V_TDEST(dest1), .Output_1_V_TVALID(valid1),
    .Output_1_V_TREADY(out_ready)
  );
  stream_rr_merge #(.DATA_WIDTH(32), .NUM_IN(2), .FIFO_DEPTH(4), .BURST_LEN(3)) d3 (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start), .ap_idle(idle3),
    .Input_V_TDATA(in_data), .Input_V_TVALID(in_valid), .Input_V_TREADY(rdy3),
    .Output_1_V_TDATA(data3), .Output_1_V_TDEST(dest3), .Output_1_V_TVALID(valid3),
    .Output_1_V_TREADY(out_ready)
  );
  task automatic reset_start();
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 2'b00;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic preload(input int n);
    for (int k = 0; k < n; k++) begin
      in_data = {32'hB0 + 32'(k), 32'hA0 + 32'(k)};
      in_valid = 2'b11;
      @(negedge clk);
    end
    in_valid = 2'b00;
  endtask
  task automatic drain(input int cycles);
    q1_d.delete();
    q3_d.delete();
    q1_t.delete();
    q3_t.delete();
    out_ready = 1'b1;
    repeat (cycles) begin
      if (valid1) begin
        q1_d.push_back(data1);
        q1_t.push_back(dest1);
      end
      if (valid3) begin
        q3_d.push_back(data3);
        q3_t.push_back(dest3);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 2'b00;
    in_data = '0;
    out_ready = 1'b0;
    #1;
    n_chk += 5;
    if (valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid1); end
    if (data1 !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", data1); end
    if (dest1 !== 1'b0) begin n_fail++; $display("FAIL reset_dest: got %b expected 0", dest1); end
    if (rdy1 !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", rdy1); end
    if (idle1 !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b expected 1", idle1); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    in_valid = 2'b11;
    in_data = {32'h55, 32'h44};
    repeat (3) begin
      @(negedge clk);
      n_chk++;
      if (rdy1 !== 2'b00) begin n_fail++; $display("FAIL gate_ready: got %b expected 00", rdy1); end
    end
    in_valid = 2'b00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_chk += 3;
    if (rdy1 !== 2'b11) begin n_fail++; $display("FAIL start_ready: got %b expected 11", rdy1); end
    if (rdy3 !== 2'b11) begin n_fail++; $display("FAIL start_ready_b3: got %b expected 11", rdy3); end
    if (idle1 !== 1'b1) begin n_fail++; $display("FAIL start_idle: got %b expected 1", idle1); end
    @(negedge clk);
    n_chk++;
    if (rdy1 !== 2'b11) begin n_fail++; $display("FAIL sticky_run: got %b expected 11", rdy1); end
  endtask
  task automatic test_latency();
    in_data = {32'h11, 32'h0};
    in_valid = 2'b10;
    @(negedge clk);
    in_valid = 2'b00;
    n_chk += 2;
    if (valid1 !== 1'b0) begin n_fail++; $display("FAIL lat_early_valid: got %b expected 0", valid1); end
    if (idle1 !== 1'b0) begin n_fail++; $display("FAIL lat_early_idle: got %b expected 0", idle1); end
    @(negedge clk);
    n_chk += 5;
    if (valid1 !== 1'b1) begin n_fail++; $display("FAIL lat_valid: got %b expected 1", valid1); end
    if (data1 !== 32'h11) begin n_fail++; $display("FAIL lat_data: got %h expected 11", data1); end
    if (dest1 !== 1'b1) begin n_fail++; $display("FAIL lat_dest: got %b expected 1", dest1); end
    if (idle1 !== 1'b0) begin n_fail++; $display("FAIL lat_idle: got %b expected 0", idle1); end
    if (data3 !== 32'h11) begin n_fail++; $display("FAIL lat_data_b3: got %h expected 11", data3); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_chk += 3;
    if (valid1 !== 1'b0) begin n_fail++; $display("FAIL lat_consumed_valid: got %b expected 0", valid1); end
    if (idle1 !== 1'b1) begin n_fail++; $display("FAIL lat_consumed_idle: got %b expected 1", idle1); end
    if (data1 !== 32'h11) begin n_fail++; $display("FAIL lat_hold_data: got %h expected 11", data1); end
  endtask
  task automatic test_round_robin();
    reset_start();
    preload(4);
    drain(20);
    n_chk++;
    if (q1_d.size() !== 8) begin n_fail++; $display("FAIL rr_count: got %0d expected 8", q1_d.size()); end
    for (int k = 0; k < 8 && k < q1_d.size(); k++) begin
      n_chk += 2;
      if (q1_d[k] !== exp_rr_d[k]) begin n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", k, q1_d[k], exp_rr_d[k]); end
      if (q1_t[k] !== exp_rr_t[k]) begin n_fail++; $display("FAIL rr_dest[%0d]: got %b expected %b", k, q1_t[k], exp_rr_t[k]); end
    end
  endtask
  task automatic test_burst();
    reset_start();
    preload(4);
    drain(20);
    n_chk++;
    if (q3_d.size() !== 8) begin n_fail++; $display("FAIL burst_count: got %0d expected 8", q3_d.size()); end
    for (int k = 0; k < 8 && k < q3_d.size(); k++) begin
      n_chk += 2;
      if (q3_d[k] !== exp_bu_d[k]) begin n_fail++; $display("FAIL burst_data[%0d]: got %h expected %h", k, q3_d[k], exp_bu_d[k]); end
      if (q3_t[k] !== exp_bu_t[k]) begin n_fail++; $display("FAIL burst_dest[%0d]: got %b expected %b", k, q3_t[k], exp_bu_t[k]); end
    end
  endtask
  task automatic test_back_pressure();
    int acc;
    logic took;
    reset_start();
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      in_data = {32'h0, 32'hC0 + 32'(acc)};
      in_valid = (acc < 8) ? 2'b01 : 2'b00;
      took = rdy1[0] && acc < 8;
      @(negedge clk);
      if (took) acc++;
    end
    in_valid = 2'b00;
    n_chk += 4;
    if (acc !== 5) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 5", acc); end
    if (rdy1[0] !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b expected 0", rdy1[0]); end
    if (valid1 !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", valid1); end
    if (data1 !== 32'hC0) begin n_fail++; $display("FAIL bp_hold_data: got %h expected c0", data1); end
    drain(15);
    n_chk++;
    if (q1_d.size() !== 5) begin n_fail++; $display("FAIL bp_count: got %0d expected 5", q1_d.size()); end
    for (int k = 0; k < 5 && k < q1_d.size(); k++) begin
      n_chk++;
      if (q1_d[k] !== 32'hC0 + 32'(k)) begin n_fail++; $display("FAIL bp_data[%0d]: got %h expected %h", k, q1_d[k], 32'hC0 + 32'(k)); end
    end
  endtask
  task automatic test_mid_reset();
    reset_start();
    preload(2);
    n_chk++;
    if (valid1 !== 1'b1) begin n_fail++; $display("FAIL mr_pre_valid: got %b expected 1", valid1); end
    #2 rst_n = 1'b0;
    #1;
    n_chk += 5;
    if (valid1 !== 1'b0) begin n_fail++; $display("FAIL mr_valid: got %b expected 0", valid1); end
    if (data1 !== 32'h0) begin n_fail++; $display("FAIL mr_data: got %h expected 0", data1); end
    if (dest1 !== 1'b0) begin n_fail++; $display("FAIL mr_dest: got %b expected 0", dest1); end
    if (idle1 !== 1'b1) begin n_fail++; $display("FAIL mr_idle: got %b expected 1", idle1); end
    if (rdy1 !== 2'b00) begin n_fail++; $display("FAIL mr_ready: got %b expected 00", rdy1); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (rdy1 !== 2'b00) begin n_fail++; $display("FAIL mr_run_cleared: got %b expected 00", rdy1); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(10);
    n_chk += 3;
    if (q1_d.size() !== 0) begin n_fail++; $display("FAIL mr_stale: got %0d words expected 0", q1_d.size()); end
    if (q3_d.size() !== 0) begin n_fail++; $display("FAIL mr_stale_b3: got %0d words expected 0", q3_d.size()); end
    if (idle1 !== 1'b1) begin n_fail++; $display("FAIL mr_final_idle: got %b expected 1", idle1); end
  endtask
  initial begin
    test_reset();
    test_latency();
    test_round_robin();
    test_burst();
    test_back_pressure();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
